prefetch_initiate_multilane_fifo: RTL
=====================================

PREFETCH_INITIATE_MULTILANE_FIFO -- requirements
Module: prefetch_initiate_multilane_fifo

Interface
REQ-001 Parameter LINE, default 18: address width in bits.
REQ-002 Parameter DEPTH, default 64: command slots; SHALL be a power of two, at least 4.
REQ-003 Parameter LANES, default 4: maximum addresses emitted per pop cycle; SHALL be 1, 2, 4 or 8.
REQ-004 Parameter MAX_COPY, default 16: largest legal copy_count.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 we  input  1  push request.
REQ-008 dat_w  input  initiate_prefetch_command  command with fields {addr[LINE], d_addr[LINE], copy_count}.
REQ-009 re  input  1  pop request (consumer ready).
REQ-010 dat_r  output  LANES x LINE  emitted addresses; lane 0 is the lowest index.
REQ-011 dat_r_valid  output  LANES  per-lane valid mask, always contiguous from lane 0.
REQ-012 full  output  1  high when no command slot is free.
REQ-013 emptyn  output  1  high when at least one address is still pending.
REQ-014 flush  input  1  present only under PREFETCH_FIFO_FLUSH_EN.

Function
REQ-015 Command i expands to addresses addr + k*d_addr for k = 0..copy_count-1, computed modulo 2^LINE; wrap-around SHALL be silent.
REQ-016 A push SHALL be accepted when we && !full; an accepted command is stored at the write pointer and the pointer advances, modulo DEPTH.
REQ-017 full SHALL equal (stored commands == DEPTH) and be driven from registered state; a push at full SHALL be dropped even when a pop retires a command in the same cycle.
REQ-018 A command with copy_count == 0 or copy_count > MAX_COPY SHALL be dropped without being stored, and a simulation assertion SHALL fire.
REQ-019 A pop cycle occurs on re && emptyn: the block emits n = min(LANES, remaining) addresses of the head command, lanes 0..n-1, with consecutive k.
REQ-020 A lane SHALL never carry an address from a different command than the other lanes in the same cycle; the tail of a command is emitted in a short beat.
REQ-021 Output latency SHALL be one cycle: dat_r and dat_r_valid are registered and reflect the pop cycle of the preceding edge.
REQ-022 On re && !emptyn, dat_r_valid SHALL become 0 and dat_r SHALL hold its value; on !re, dat_r and dat_r_valid SHALL hold their values.
REQ-023 The per-command offset counter SHALL advance by n; when it reaches copy_count, the command retires, the read pointer advances and the counter clears, all on the same edge.
REQ-024 Lane addresses SHALL be formed as base + lane*d_addr, where base is a registered running address updated by LANES*d_addr, so that no multiplier depends on the counter.
REQ-025 Simultaneous push and pop SHALL both take effect; a push into an empty FIFO SHALL be poppable on the next cycle.
REQ-026 emptyn SHALL be high when any command is stored.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear the read and write pointers, the count, the offset counter, the base register, dat_r and dat_r_valid, and SHALL force full=0 and emptyn=0; storage contents are not reset.
REQ-028 Reset during a partially emitted command SHALL discard that command and all queued commands.

Configuration
REQ-029 With PREFETCH_FIFO_FLUSH_EN defined, flush high at an edge SHALL empty the FIFO and clear the offset counter and dat_r_valid; flush SHALL take priority over a push and a pop in the same cycle.
REQ-030 Without PREFETCH_FIFO_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
REQ-031 The initiate_prefetch_command typedef, the copy_count width $clog2(MAX_COPY+1), and the default LINE, DEPTH, LANES and MAX_COPY values SHALL live in the shared prefetch package.
REQ-032 Lane address generation SHALL be one sub-module, prefetch_lane_addr_gen (inputs base, d_addr, n; outputs dat_r and the valid mask).

Verification
REQ-033 LANES=4; push {addr=0x100, d_addr=4, copy=10}; hold re high -> beats {100,104,108,10C}, {110,114,118,11C}, {120,124} with masks 1111, 1111, 0011.
REQ-034 LINE=18; push {addr=0x3FFF8, d_addr=8, copy=3} -> 3FFF8, 00000, 00008, wrapping without error.
REQ-035 Fill DEPTH commands -> full=1; 65th push with re high in the same cycle -> dropped, and the count after the edge is DEPTH-1.
REQ-036 Push copy=0 -> assertion fires, emptyn stays 0; push copy=1 on the next cycle -> a single beat with mask 0001.
REQ-037 Drive reset_n low mid-command, after 2 of 3 beats -> outputs clear immediately; after release, emptyn=0 and a new push emits from k=0.
REQ-038 With PREFETCH_FIFO_FLUSH_EN, flush together with we and re on a full FIFO -> empty next cycle, push discarded, dat_r_valid=0.

Source files
------------

// File: rtl/prefetch_initiate_multilane_fifo_pkg.sv
// Shared definitions for the multilane prefetch-initiate FIFO.
// Contents:
//   - default LINE / DEPTH / LANES / MAX_COPY values
//   - copy_count width, $clog2(MAX_COPY+1)
//   - initiate_prefetch_command: {addr, d_addr, copy_count}
//   - copy_legal(): a command is storable only with 1 <= copy_count <= max_copy
package prefetch_initiate_multilane_fifo_pkg;

   localparam int PF_LINE     = 18;
   localparam int PF_DEPTH    = 64;
   localparam int PF_LANES    = 4;
   localparam int PF_MAX_COPY = 16;
   localparam int PF_CNT_W    = $clog2(PF_MAX_COPY + 1);

   typedef struct packed {
      logic [PF_LINE-1:0]  addr;
      logic [PF_LINE-1:0]  d_addr;
      logic [PF_CNT_W-1:0] copy_count;
   } initiate_prefetch_command;

   function automatic logic copy_legal(input logic [PF_CNT_W-1:0] cc, input int max_copy);
      logic ok;
      if ((cc != {PF_CNT_W{1'b0}}) && (int'(cc) <= max_copy)) begin
         ok = 1'b1;
      end else begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/prefetch_initiate_multilane_fifo_chk.sv
// Checker for the prefetch FIFO: flags every push request whose copy_count is
// outside 1..MAX_COPY. Such commands are silently dropped by the datapath.
// Ports:
//   clk, reset_n  in  clock and asynchronous active-low reset
//   we            in  push request
//   copy_count    in  copy_count field of the pushed command
module prefetch_initiate_multilane_fifo_chk
   import prefetch_initiate_multilane_fifo_pkg::*;
#(
   parameter int MAX_COPY = PF_MAX_COPY
) (
   input logic                clk,
   input logic                reset_n,
   input logic                we,
   input logic [PF_CNT_W-1:0] copy_count
);

   illegal_copy_count: assert property (@(posedge clk) disable iff (!reset_n)
      we |-> copy_legal(copy_count, MAX_COPY))
      else $warning("prefetch fifo: push with illegal copy_count %0d dropped", copy_count);

endmodule

// File: rtl/prefetch_initiate_multilane_fifo_lane_addr_gen.sv
// prefetch_lane_addr_gen: combinational lane address generator.
// Lane l carries base + l*d_addr (mod 2^LINE); lanes 0..n-1 are flagged valid.
// Ports:
//   base        in   LINE        address of the first lane in this beat
//   d_addr      in   LINE        stride between consecutive addresses
//   n           in   NW          number of addresses in this beat (0..LANES)
//   dat_r       out  LANES*LINE  lane addresses, lane 0 in the low bits
//   dat_r_valid out  LANES       contiguous valid mask from lane 0
module prefetch_lane_addr_gen
   import prefetch_initiate_multilane_fifo_pkg::*;
#(
   parameter int LINE  = PF_LINE,
   parameter int LANES = PF_LANES,
   parameter int NW    = $clog2(LANES + 1)
) (
   input  logic [LINE-1:0]       base,
   input  logic [LINE-1:0]       d_addr,
   input  logic [NW-1:0]         n,
   output logic [LANES*LINE-1:0] dat_r,
   output logic [LANES-1:0]      dat_r_valid
);

   // Each lane multiplies d_addr by a constant lane index only; the beat-to-beat
   // progression comes from the registered base, so nothing here depends on the
   // per-command offset counter.
   always_comb begin
      dat_r       = {(LANES*LINE){1'b0}};
      dat_r_valid = {LANES{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         dat_r[l*LINE +: LINE] = base + LINE'(l) * d_addr;
         if (l < int'(n)) begin
            dat_r_valid[l] = 1'b1;
         end else begin
            dat_r_valid[l] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/prefetch_initiate_multilane_fifo.sv
// prefetch_initiate_multilane_fifo: command FIFO that expands each stored
// {addr, d_addr, copy_count} command into copy_count strided addresses and
// emits up to LANES of them per pop cycle, never mixing two commands in a beat.
// Optional feature macro: PREFETCH_FIFO_FLUSH_EN adds the synchronous flush input.
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   we, dat_w    in   push request and command
//   re           in   pop request (consumer ready)
//   flush        in   empties the FIFO (PREFETCH_FIFO_FLUSH_EN only)
//   dat_r        out  LANES*LINE registered lane addresses, lane 0 low
//   dat_r_valid  out  LANES registered contiguous valid mask
//   full         out  no command slot free
//   emptyn       out  at least one command still stored
module prefetch_initiate_multilane_fifo
   import prefetch_initiate_multilane_fifo_pkg::*;
#(
   parameter int LINE     = PF_LINE,
   parameter int DEPTH    = PF_DEPTH,
   parameter int LANES    = PF_LANES,
   parameter int MAX_COPY = PF_MAX_COPY
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     we,
   input  initiate_prefetch_command dat_w,
   input  logic                     re,
`ifdef PREFETCH_FIFO_FLUSH_EN
   input  logic                     flush,
`endif
   output logic [LANES*LINE-1:0]    dat_r,
   output logic [LANES-1:0]         dat_r_valid,
   output logic                     full,
   output logic                     emptyn
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW2 = AW + 1;
   localparam int NW  = $clog2(LANES + 1);
   localparam int LSH = $clog2(LANES);

   initiate_prefetch_command mem_r [DEPTH];

   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CW2-1:0]         count_r;
   logic [PF_CNT_W-1:0]    off_r;
   logic [LINE-1:0]        base_r;
   logic [LANES*LINE-1:0]  dat_r_r;
   logic [LANES-1:0]       dat_r_valid_r;
   logic                   full_r;
   logic                   emptyn_r;

   initiate_prefetch_command head_s;
   logic [PF_CNT_W-1:0]    remain_s;
   logic [PF_CNT_W-1:0]    off_next_s;
   logic [NW-1:0]          n_s;
   logic [LINE-1:0]        cur_base_s;
   logic [CW2-1:0]         count_next_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   retire_s;
   logic [LANES*LINE-1:0]  lane_dat_s;
   logic [LANES-1:0]       lane_valid_s;

   // Head-of-queue beat sizing, push/pop/retire decisions and next occupancy.
   always_comb begin
      head_s   = mem_r[rd_ptr_r];
      remain_s = head_s.copy_count - off_r;
      if (remain_s > PF_CNT_W'(LANES)) begin
         n_s = NW'(LANES);
      end else begin
         n_s = NW'(remain_s);
      end
      off_next_s = off_r + PF_CNT_W'(n_s);
      // First beat of a command starts at its own addr; later beats use the
      // running base that was advanced by LANES*d_addr on the previous beat.
      if (off_r == {PF_CNT_W{1'b0}}) begin
         cur_base_s = head_s.addr;
      end else begin
         cur_base_s = base_r;
      end
      pop_s    = re && emptyn_r;
      retire_s = pop_s && (off_next_s == head_s.copy_count);
      // full_r is the pre-edge state, so a push at full is dropped even if a
      // command retires on the same edge.
      push_s = we && !full_r && copy_legal(dat_w.copy_count, MAX_COPY);
`ifdef PREFETCH_FIFO_FLUSH_EN
      if (flush) begin
         push_s = 1'b0;
      end else begin
         push_s = push_s;
      end
`endif
      count_next_s = count_r + CW2'(push_s) - CW2'(retire_s);
   end

   prefetch_lane_addr_gen #(
      .LINE  (LINE),
      .LANES (LANES),
      .NW    (NW)
   ) u_lane_gen (
      .base        (cur_base_s),
      .d_addr      (head_s.d_addr),
      .n           (n_s),
      .dat_r       (lane_dat_s),
      .dat_r_valid (lane_valid_s)
   );

   // Command storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= dat_w;
      end
   end

   // Pointers, occupancy, per-command progress and registered beat outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r      <= {AW{1'b0}};
         rd_ptr_r      <= {AW{1'b0}};
         count_r       <= {CW2{1'b0}};
         off_r         <= {PF_CNT_W{1'b0}};
         base_r        <= {LINE{1'b0}};
         dat_r_r       <= {(LANES*LINE){1'b0}};
         dat_r_valid_r <= {LANES{1'b0}};
         full_r        <= 1'b0;
         emptyn_r      <= 1'b0;
      end
`ifdef PREFETCH_FIFO_FLUSH_EN
      else if (flush) begin
         wr_ptr_r      <= {AW{1'b0}};
         rd_ptr_r      <= {AW{1'b0}};
         count_r       <= {CW2{1'b0}};
         off_r         <= {PF_CNT_W{1'b0}};
         base_r        <= {LINE{1'b0}};
         dat_r_valid_r <= {LANES{1'b0}};
         full_r        <= 1'b0;
         emptyn_r      <= 1'b0;
      end
`endif
      else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (retire_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r  <= count_next_s;
         full_r   <= (count_next_s == CW2'(DEPTH));
         emptyn_r <= (count_next_s != {CW2{1'b0}});
         if (pop_s) begin
            dat_r_r       <= lane_dat_s;
            dat_r_valid_r <= lane_valid_s;
            if (retire_s) begin
               off_r  <= {PF_CNT_W{1'b0}};
               base_r <= {LINE{1'b0}};
            end else begin
               off_r  <= off_next_s;
               base_r <= cur_base_s + (head_s.d_addr << LSH);
            end
         end else if (re) begin
            // Consumer ready but nothing pending: drop valid, hold data.
            dat_r_valid_r <= {LANES{1'b0}};
         end else begin
            dat_r_valid_r <= dat_r_valid_r;
         end
      end
   end

   assign dat_r       = dat_r_r;
   assign dat_r_valid = dat_r_valid_r;
   assign full        = full_r;
   assign emptyn      = emptyn_r;

   prefetch_initiate_multilane_fifo_chk #(
      .MAX_COPY (MAX_COPY)
   ) u_chk (
      .clk        (clk),
      .reset_n    (reset_n),
      .we         (we),
      .copy_count (dat_w.copy_count)
   );

endmodule
